icache_fill_ctrl: RTL and testbench

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

---
 rtl/icache_fill_ctrl.sv | 93 +++++++++
 tb/tb_icache_fill_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - instruction cache miss/fill controller
// Takes a miss, requests the 8-word block, writes it back and counts hits and misses.
module icache_fill_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic [31:0]      pc,
  input  logic             hit,
  input  logic             miss,
  input  logic             flush,
  input  logic             mem_ack,
  output logic             stall,
  output logic             update,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic             err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q;
  logic [26:0]      blk_q;
  logic [7:0]       wait_q;
  logic             err_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  logic take_miss;
  logic blk_match;
  logic unused_pc_bits;

  assign take_miss      = en && miss && !flush;
  assign blk_match      = (pc[31:5] == blk_q);
  assign unused_pc_bits = ^pc[4:0];

  // Outputs decoded from state are gated by reset so a reset mid-fill never strobes.
  assign mem_req  = RST_N && (state_q == REQ);
  assign update   = RST_N && (state_q == FILL) && blk_match;
  assign stall    = (RST_N && (state_q != IDLE)) || take_miss;
  assign mem_addr = {blk_q, 5'b0};
  assign err      = err_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if ((state_q == IDLE) && en && hit && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          if (take_miss) begin
            state_q <= REQ;
            blk_q   <= pc[31:5];
            wait_q  <= '0;
            if (miss_cnt_q != '1)
              miss_cnt_q <= miss_cnt_q + CNT_W'(1);
          end
        end
        REQ: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (mem_ack) begin
            state_q <= FILL;
          end else if (wait_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        // A PC that left the block during the request skips the write entirely.
        FILL:    state_q <= blk_match ? DONE : IDLE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - table-driven bench for icache_fill_ctrl
module tb_icache_fill_ctrl;

  logic        CLK;
  logic        rst_n, en, hit, miss, flush, mem_ack;
  logic [31:0] pc;
  logic        stall, update, mem_req, err;
  logic [31:0] mem_addr, hit_cnt, miss_cnt;

  logic        en2, hit2;
  logic        stall2, update2, mem_req2, err2;
  logic [31:0] mem_addr2;
  logic [3:0]  hit_cnt2, miss_cnt2;

  int tests = 0;
  int fails = 0;

  icache_fill_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .CLK(CLK), .RST_N(rst_n), .en(en), .pc(pc), .hit(hit), .miss(miss),
    .flush(flush), .mem_ack(mem_ack), .stall(stall), .update(update),
    .mem_req(mem_req), .mem_addr(mem_addr), .err(err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  icache_fill_ctrl #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .RST_N(rst_n), .en(en2), .pc(pc), .hit(hit2), .miss(1'b0),
    .flush(1'b0), .mem_ack(1'b0), .stall(stall2), .update(update2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .err(err2),
    .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rst_n, en;
    logic [31:0] pc;
    logic        hit, miss, flush, ack;
    logic        e_stall, e_upd, e_req, e_err;
    logic [31:0] e_hc, e_mc, e_addr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [31:0] p,
                     input logic h, input logic m, input logic f, input logic a,
                     input logic es, input logic eu, input logic er, input logic ee,
                     input logic [31:0] ehc, input logic [31:0] emc, input logic [31:0] ead);
    vec_t v;
    v.rst_n = r; v.en = e; v.pc = p; v.hit = h; v.miss = m; v.flush = f; v.ack = a;
    v.e_stall = es; v.e_upd = eu; v.e_req = er; v.e_err = ee;
    v.e_hc = ehc; v.e_mc = emc; v.e_addr = ead;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic cycle(input logic e, input logic [31:0] p, input logic h,
                       input logic m, input logic f, input logic a);
    en = e; pc = p; hit = h; miss = m; flush = f; mem_ack = a;
    @(posedge CLK); #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 0; pc = '0; hit = 0; miss = 0; flush = 0; mem_ack = 0;
    en2 = 0; hit2 = 0;
    @(posedge CLK); @(posedge CLK); #1;

    //  rst en pc            h m f a   stl upd req err hc mc addr
    add(0, 0, 32'h0,         0,0,0,0,  0,0,0,0, 0,0,32'h0);
    add(1, 1, 32'h124,       0,1,0,0,  1,0,0,0, 0,0,32'h0);
    add(1, 1, 32'h124,       0,1,0,1,  1,0,1,0, 0,1,32'h120);
    add(1, 1, 32'h124,       0,1,0,1,  1,1,0,0, 0,1,32'h120);
    add(1, 1, 32'h124,       1,0,0,1,  1,0,0,0, 0,1,32'h120);
    add(1, 1, 32'h124,       1,0,0,0,  0,0,0,0, 0,1,32'h120);
    add(1, 1, 32'h124,       1,0,0,0,  0,0,0,0, 1,1,32'h120);
    // flush racing mem_ack in REQ
    add(1, 1, 32'h2000_0040, 0,1,0,0,  1,0,0,0, 2,1,32'h120);
    add(1, 1, 32'h2000_0040, 0,1,1,1,  1,0,1,0, 2,2,32'h2000_0040);
    add(1, 0, 32'h2000_0040, 0,0,0,0,  0,0,0,0, 2,2,32'h2000_0040);
    // pc leaves the block during REQ
    add(1, 1, 32'h1000,      0,1,0,0,  1,0,0,0, 2,2,32'h2000_0040);
    add(1, 1, 32'h1020,      0,0,0,1,  1,0,1,0, 2,3,32'h1000);
    add(1, 1, 32'h1020,      0,1,0,0,  1,0,0,0, 2,3,32'h1000);
    add(1, 0, 32'h1020,      0,0,0,0,  0,0,0,0, 2,3,32'h1000);
    // miss arriving in DONE waits for IDLE
    add(1, 1, 32'h40,        0,1,0,0,  1,0,0,0, 2,3,32'h1000);
    add(1, 1, 32'h40,        0,1,0,1,  1,0,1,0, 2,4,32'h40);
    add(1, 1, 32'h40,        0,1,0,0,  1,1,0,0, 2,4,32'h40);
    add(1, 1, 32'h80,        0,1,0,0,  1,0,0,0, 2,4,32'h40);
    add(1, 1, 32'h80,        0,1,0,0,  1,0,0,0, 2,4,32'h40);
    // timeout with TIMEOUT=4
    add(1, 0, 32'h80,        0,0,0,0,  1,0,1,0, 2,5,32'h80);
    add(1, 0, 32'h80,        0,0,0,0,  1,0,1,0, 2,5,32'h80);
    add(1, 0, 32'h80,        0,0,0,0,  1,0,1,0, 2,5,32'h80);
    add(1, 0, 32'h80,        0,0,0,0,  1,0,1,0, 2,5,32'h80);
    add(1, 0, 32'h80,        0,0,0,0,  0,0,0,1, 2,5,32'h80);
    add(1, 0, 32'h80,        0,0,0,0,  0,0,0,1, 2,5,32'h80);
    // reset asserted in FILL
    add(1, 1, 32'h124,       0,1,0,0,  1,0,0,1, 2,5,32'h80);
    add(1, 0, 32'h124,       0,0,0,1,  1,0,1,1, 2,6,32'h120);
    add(0, 0, 32'h124,       0,0,0,0,  0,0,0,1, 2,6,32'h120);
    add(1, 0, 32'h124,       0,0,0,0,  0,0,0,0, 0,0,32'h0);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; en = vq[i].en; pc = vq[i].pc; hit = vq[i].hit;
      miss = vq[i].miss; flush = vq[i].flush; mem_ack = vq[i].ack;
      @(negedge CLK);
      tests++;
      if ({stall, update, mem_req, err} !== {vq[i].e_stall, vq[i].e_upd, vq[i].e_req, vq[i].e_err} ||
          hit_cnt !== vq[i].e_hc || miss_cnt !== vq[i].e_mc || mem_addr !== vq[i].e_addr) begin
        fails++;
        $display("FAIL vec%0d: got stall/upd/req/err=%b%b%b%b hc=%0d mc=%0d addr=%08h, expected %b%b%b%b hc=%0d mc=%0d addr=%08h",
                 i, stall, update, mem_req, err, hit_cnt, miss_cnt, mem_addr,
                 vq[i].e_stall, vq[i].e_upd, vq[i].e_req, vq[i].e_err,
                 vq[i].e_hc, vq[i].e_mc, vq[i].e_addr);
      end
      @(posedge CLK); #1;
    end

    // ten hits then one serviced miss
    for (int k = 0; k < 10; k++) cycle(1, 32'h300, 1, 0, 0, 0);
    cycle(1, 32'h300, 0, 1, 0, 0);
    check("upd_req_excl_req", {31'b0, update & mem_req}, 32'h0);
    cycle(1, 32'h300, 0, 1, 0, 1);
    check("fill_update", {31'b0, update}, 32'h1);
    cycle(1, 32'h300, 0, 1, 0, 0);
    cycle(1, 32'h300, 1, 0, 0, 0);
    check("hit_cnt_10", hit_cnt, 32'd10);
    check("miss_cnt_1", miss_cnt, 32'd1);
    check("stall_after_fill", {31'b0, stall}, 32'h0);

    // saturation on the 4-bit counter instance
    en2 = 1; hit2 = 1;
    for (int k = 0; k < 15; k++) cycle(0, 32'h0, 0, 0, 0, 0);
    check("sat_reach", {28'b0, hit_cnt2}, 32'hF);
    cycle(0, 32'h0, 0, 0, 0, 0);
    check("sat_hold", {28'b0, hit_cnt2}, 32'hF);
    en2 = 0; hit2 = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
